// File: rtl/cache_proc_req_ctrl.sv
// Processor-side MESI request controller: classifies hit/miss, writes back a dirty
// victim, issues the bus request, and commits the line's new MESI state.
module cache_proc_req_ctrl #(
    parameter int RSP_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             proc_req_vld,
    input  logic             proc_req_op,
    input  logic             proc_hit,
    input  logic [3:0]       cur_state,
    input  logic             line_snoop_inv,
    output logic             proc_done,
    output logic             proc_err,
    output logic             busy,
    output logic             mem_wb_req,
    input  logic             mem_wb_ack,
    output logic [1:0]       bus_req,
    input  logic             bus_gnt,
    input  logic             bus_rsp_vld,
    input  logic [1:0]       bus_rsp,
    output logic             state_upd_en,
    output logic [3:0]       nxt_state
);

    localparam logic [3:0] INVALID   = 4'b0001;
    localparam logic [3:0] SHARED    = 4'b0010;
    localparam logic [3:0] EXCLUSIVE = 4'b0100;
    localparam logic [3:0] MODIFIED  = 4'b1000;

    localparam logic [1:0] BUS_NO_REQ         = 2'b00;
    localparam logic [1:0] BUS_READ_REQ       = 2'b01;
    localparam logic [1:0] BUS_RWITM_REQ      = 2'b10;
    localparam logic [1:0] BUS_INVALIDATE_REQ = 2'b11;

    localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'b01;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(RSP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, WB, WAIT_GNT, WAIT_RSP, DONE} state_t;

    state_t           state, state_d;
    logic [1:0]       pend_req, pend_req_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic             done_d, err_d, wb_d, upd_d, hit_eff;
    logic [1:0]       bus_req_d;
    logic [3:0]       nxt_state_d;

    assign cnt_inc = cnt + 1'b1;
    assign hit_eff = proc_hit && (cur_state != INVALID);

    always_comb begin
        state_d     = state;
        pend_req_d  = pend_req;
        cnt_d       = cnt;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wb_d        = 1'b0;
        upd_d       = 1'b0;
        bus_req_d   = BUS_NO_REQ;
        nxt_state_d = nxt_state;
        unique case (state)
            IDLE: begin
                if (proc_req_vld) begin
                    if (hit_eff) begin
                        if (proc_req_op && cur_state == SHARED) begin
                            pend_req_d = BUS_INVALIDATE_REQ;
                            bus_req_d  = BUS_INVALIDATE_REQ;
                            state_d    = WAIT_GNT;
                        end else begin
                            // Read hits and write hits on M/E complete locally.
                            state_d = DONE;
                            done_d  = 1'b1;
                            if (proc_req_op && cur_state == EXCLUSIVE) begin
                                upd_d       = 1'b1;
                                nxt_state_d = MODIFIED;
                            end
                        end
                    end else begin
                        pend_req_d = proc_req_op ? BUS_RWITM_REQ : BUS_READ_REQ;
                        if (cur_state == MODIFIED) begin
                            state_d = WB;
                            wb_d    = 1'b1;
                        end else begin
                            state_d   = WAIT_GNT;
                            bus_req_d = pend_req_d;
                        end
                    end
                end
            end
            WB: begin
                if (mem_wb_ack) begin
                    state_d   = WAIT_GNT;
                    bus_req_d = pend_req;
                end else begin
                    wb_d = 1'b1;
                end
            end
            WAIT_GNT: begin
                bus_req_d = pend_req;
                // Losing the line to a snoop outranks a simultaneous grant.
                if (line_snoop_inv && pend_req == BUS_INVALIDATE_REQ) begin
                    pend_req_d = BUS_RWITM_REQ;
                    bus_req_d  = BUS_RWITM_REQ;
                end else if (bus_gnt) begin
                    state_d = WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                bus_req_d = pend_req;
                cnt_d     = cnt_inc;
                if (bus_rsp_vld) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    upd_d     = 1'b1;
                    bus_req_d = BUS_NO_REQ;
                    if (pend_req == BUS_READ_REQ)
                        nxt_state_d = (bus_rsp == BUS_SNOOP_FOUND_RSP) ? SHARED : EXCLUSIVE;
                    else
                        nxt_state_d = MODIFIED;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    bus_req_d = BUS_NO_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pend_req     <= BUS_NO_REQ;
            cnt          <= '0;
            proc_done    <= 1'b0;
            proc_err     <= 1'b0;
            busy         <= 1'b0;
            mem_wb_req   <= 1'b0;
            bus_req      <= BUS_NO_REQ;
            state_upd_en <= 1'b0;
            nxt_state    <= INVALID;
        end else begin
            state        <= state_d;
            pend_req     <= pend_req_d;
            cnt          <= cnt_d;
            proc_done    <= done_d;
            proc_err     <= err_d;
            busy         <= (state_d != IDLE);
            mem_wb_req   <= wb_d;
            bus_req      <= bus_req_d;
            state_upd_en <= upd_d;
            nxt_state    <= nxt_state_d;
        end
    end

endmodule

// File: doc/cache_proc_req_ctrl.md
Name: cache_proc_req_ctrl

Overview:
Processor-side (initiator) controller for one MESI cache. It accepts a processor read/write, classifies it as a hit or a miss, and writes back a MODIFIED victim when needed. It then issues BUS_READ_REQ, BUS_RWITM_REQ or BUS_INVALIDATE_REQ, waits for bus grant and the aggregated snoop response, and commits the line's new MESI state. It is the requesting counterpart of the snoop-side bus-request FSM, and shares the cache_def.v state and bus encodings.

Parameters:
RSP_TIMEOUT, 255, number of WAIT_RSP cycles without bus_rsp_vld before the transaction aborts (must be >=1).
CNT_W, 8, width of the timeout counter (2^CNT_W-1 >= RSP_TIMEOUT).

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  asynchronous active-low reset.
proc_req_vld  in  1  processor request valid; sampled only in IDLE.
proc_req_op  in  1  0 = read, 1 = write.
proc_hit  in  1  tag hit for the addressed line.
cur_state  in  4  MESI state of the hit line, or of the victim line on a miss.
line_snoop_inv  in  1  the snoop FSM invalidated the addressed line this cycle.
proc_done  out  1  one-cycle completion pulse.
proc_err  out  1  valid with proc_done; 1 = response timeout.
busy  out  1  1 whenever the FSM is not in IDLE.
mem_wb_req  out  1  victim write-back request; held until mem_wb_ack.
mem_wb_ack  in  1  write-back complete.
bus_req  out  2  BUS_NO_REQ / BUS_READ_REQ / BUS_RWITM_REQ / BUS_INVALIDATE_REQ.
bus_gnt  in  1  bus arbiter grant.
bus_rsp_vld  in  1  aggregated snoop response valid.
bus_rsp  in  2  BUS_SNOOP_FOUND_RSP or BUS_NO_RSP.
state_upd_en  out  1  write nxt_state into the line's state array.
nxt_state  out  4  new MESI state.

Behaviour:
- Reset: clk and rst_n are as stated. The clock is single; reset is asynchronous and active-low. Reset forces FSM to IDLE, proc_done=0, proc_err=0, busy=0, mem_wb_req=0, bus_req=BUS_NO_REQ, state_upd_en=0, nxt_state=INVALID, and clears the counter. Reset asserted mid-transaction aborts it with no state update and no proc_done.
- All outputs are registered (Moore). FSM states: IDLE, WB, WAIT_GNT, WAIT_RSP, DONE.
- IDLE, proc_req_vld=1: latch op/hit/cur_state. A hit with cur_state=INVALID is treated as a miss.
  - Read hit on S, E or M: go to DONE; no update.
  - Write hit on M: go to DONE; no update.
  - Write hit on E: go to DONE with nxt_state=MODIFIED (silent upgrade, no bus traffic).
  - Write hit on S: pending request = INVALIDATE; go to WAIT_GNT.
  - Miss: pending request = READ (read) or RWITM (write). If victim is M, go to WB; otherwise go to WAIT_GNT.
- WB: mem_wb_req=1 until the cycle mem_wb_ack=1, then go to WAIT_GNT. No bus request is driven during WB.
- WAIT_GNT: bus_req = pending request. On bus_gnt, go to WAIT_RSP.
  - If line_snoop_inv=1 while the pending request is INVALIDATE, the request becomes RWITM (the line was lost). When bus_gnt and line_snoop_inv fall in the same cycle, the conversion wins: stay in WAIT_GNT one more cycle driving RWITM.
- WAIT_RSP: bus_req is held; the counter increments each cycle.
  - On bus_rsp_vld, go to DONE with this nxt_state:
    - READ + BUS_SNOOP_FOUND_RSP -> SHARED.
    - READ + BUS_NO_RSP -> EXCLUSIVE.
    - RWITM -> MODIFIED.
    - INVALIDATE -> MODIFIED.
  - If the counter reaches RSP_TIMEOUT with no response, go to DONE with proc_err=1 and no update. bus_rsp_vld in the same cycle as the timeout wins.
- DONE (one cycle): proc_done=1; state_upd_en=1 only if a new state was computed. bus_req returns to BUS_NO_REQ. Next state is IDLE and the counter clears.
- A request held high after proc_done is re-accepted in the following IDLE cycle; the requester deasserts on proc_done.
- Inputs other than proc_req_vld are ignored outside the states that sample them.
- Latency:
  - Hit: proc_done 1 cycle after acceptance.
  - Bus miss: acceptance + WB cycles + grant wait + response wait + 1.

Test Plan:
- Read hit on E at T0 -> proc_done=1 at T1, state_upd_en=0, bus_req stays BUS_NO_REQ throughout.
- Write hit on E -> T1: proc_done=1, state_upd_en=1, nxt_state=MODIFIED; no bus_req.
- Read miss, victim=M; mem_wb_ack after 3 cycles, bus_gnt after 2, bus_rsp_vld with BUS_NO_RSP -> mem_wb_req high for exactly 3 cycles, then bus_req=BUS_READ_REQ, then DONE with nxt_state=EXCLUSIVE. Repeat with BUS_SNOOP_FOUND_RSP -> SHARED.
- Write hit on S; line_snoop_inv pulses in WAIT_GNT before grant -> bus_req switches INVALIDATE -> RWITM; after response, nxt_state=MODIFIED. Also cover line_snoop_inv coincident with bus_gnt.
- RSP_TIMEOUT=4, grant given, no response -> proc_done=1 and proc_err=1 after 4 WAIT_RSP cycles, state_upd_en=0, bus_req back to BUS_NO_REQ.
- Assert rst_n=0 during WAIT_RSP -> all outputs immediately at reset values, no proc_done; a new request after release completes normally.
